// File: rtl/wasm_pkg.sv
// -----------------------------------------------------------------------------
// wasm_pkg
// Shared definitions for the WebAssembly constant encoder: opcode bytes for
// the four numeric *.const instructions, the two-bit type code carried on
// in_type, and the encoder FSM state encoding.
// -----------------------------------------------------------------------------
package wasm_pkg;

    localparam logic [7:0] OP_I32_CONST = 8'h41;
    localparam logic [7:0] OP_I64_CONST = 8'h42;
    localparam logic [7:0] OP_F32_CONST = 8'h43;
    localparam logic [7:0] OP_F64_CONST = 8'h44;

    typedef enum logic [1:0] {
        TYPE_I32 = 2'd0,
        TYPE_I64 = 2'd1,
        TYPE_F32 = 2'd2,
        TYPE_F64 = 2'd3
    } const_type_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OPCODE  = 2'd1,
        ST_PAYLOAD = 2'd2
    } enc_state_e;

    function automatic logic [7:0] opcode_of(const_type_e t);
        case (t)
            TYPE_I32: opcode_of = OP_I32_CONST;
            TYPE_I64: opcode_of = OP_I64_CONST;
            TYPE_F32: opcode_of = OP_F32_CONST;
            default:  opcode_of = OP_F64_CONST;
        endcase
    endfunction

endpackage

// File: rtl/sleb128_step.sv
// -----------------------------------------------------------------------------
// sleb128_step
// One combinational step of signed LEB128 encoding. Takes the remaining
// (two's complement) value and produces the byte to emit, the value left over
// after an arithmetic shift by 7, and whether this byte terminates the code.
//   i_v      [63:0]  remaining value
//   o_byte   [7:0]   encoded byte (bit 7 = continuation flag)
//   o_v_next [63:0]  i_v >>> 7
//   o_last           this byte is the final one
// -----------------------------------------------------------------------------
module sleb128_step (
    input  logic [63:0] i_v,
    output logic [7:0]  o_byte,
    output logic [63:0] o_v_next,
    output logic        o_last
);

    logic [6:0] w_bits;

    assign w_bits   = i_v[6:0];
    assign o_v_next = 64'($signed(i_v) >>> 7);
    // The remaining value is fully described by the sign bit (bit 6) of this
    // group once everything above it is pure sign extension of that bit.
    assign o_last   = ((o_v_next == 64'd0) && !w_bits[6]) ||
                      ((o_v_next == {64{1'b1}}) && w_bits[6]);
    assign o_byte   = {~o_last, w_bits};

endmodule

// File: rtl/wasm_const_encoder.sv
// -----------------------------------------------------------------------------
// wasm_const_encoder
// Serialises one WebAssembly numeric constant into bytecode: optional opcode
// byte followed by the immediate (signed LEB128 for i32/i64, little-endian
// raw bits for f32/f64).
//   clk        clock
//   reset      synchronous active-low reset
//   in_valid   constant request valid
//   in_ready   encoder idle; request taken on in_valid & in_ready
//   in_type    0=i32 1=i64 2=f32 3=f64
//   in_value   raw bits (i32/f32 use [31:0])
//   out_valid  out_data holds a byte
//   out_ready  downstream takes byte on out_valid & out_ready
//   out_data   bytecode byte
//   out_last   final byte of current constant
// Parameter EMIT_OPCODE: 1 emits opcode first, 0 emits immediate only.
// -----------------------------------------------------------------------------
module wasm_const_encoder
    import wasm_pkg::*;
#(
    parameter bit EMIT_OPCODE = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_type,
    input  logic [63:0] in_value,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_last
);

    enc_state_e  r_state;
    const_type_e r_type;
    logic [63:0] r_val;      // value still to be emitted after the current byte
    logic [3:0]  r_cnt;      // index of the next payload byte
    logic        r_out_valid;
    logic [7:0]  r_out_data;
    logic        r_out_last;

    logic        w_idle;
    const_type_e w_type;
    logic [3:0]  w_cnt;
    logic [63:0] w_src;
    logic [7:0]  w_byte;
    logic [63:0] w_next;
    logic        w_last;
    logic [7:0]  w_leb_byte;
    logic [63:0] w_leb_next;
    logic        w_leb_last;

    assign w_idle    = (r_state == ST_IDLE);
    // Gated by reset directly so the encoder never advertises readiness while
    // held in reset, and does so from the very first cycle after release.
    assign in_ready  = reset && w_idle;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;

    // In IDLE the next-byte logic looks straight at the request so that the
    // opcode-less variant can emit its first payload byte on the accept edge.
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case statements can leave a latch behind.
    always_comb begin
        w_type = r_type;
        w_cnt  = r_cnt;
        w_src  = r_val;
        if (w_idle) begin
            w_type = const_type_e'(in_type);
            w_cnt  = 4'd0;
            case (const_type_e'(in_type))
                TYPE_I32: w_src = {{32{in_value[31]}}, in_value[31:0]};
                TYPE_F32: w_src = {32'd0, in_value[31:0]};
                default:  w_src = in_value;
            endcase
        end
    end

    sleb128_step u_leb (
        .i_v      (w_src),
        .o_byte   (w_leb_byte),
        .o_v_next (w_leb_next),
        .o_last   (w_leb_last)
    );

    always_comb begin
        w_byte = w_leb_byte;
        w_next = w_leb_next;
        w_last = w_leb_last;
        if (w_type == TYPE_F32 || w_type == TYPE_F64) begin
            w_byte = w_src[7:0];
            w_next = {8'd0, w_src[63:8]};
            w_last = (w_type == TYPE_F32) ? (w_cnt == 4'd3) : (w_cnt == 4'd7);
        end
    end

    // NOTE: state is updated with non-blocking assignments only, so every
    // right-hand side below sees the pre-edge values regardless of order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            // NOTE: only control state is reset; r_type/r_val/r_cnt are always
            // loaded on accept before they are ever used.
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_out_data  <= 8'd0;
            r_out_last  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_type      <= const_type_e'(in_type);
                        r_out_valid <= 1'b1;
                        if (EMIT_OPCODE) begin
                            r_state    <= ST_OPCODE;
                            r_out_data <= opcode_of(const_type_e'(in_type));
                            r_out_last <= 1'b0;
                            r_val      <= w_src;
                            r_cnt      <= 4'd0;
                        end else begin
                            r_state    <= ST_PAYLOAD;
                            r_out_data <= w_byte;
                            r_out_last <= w_last;
                            r_val      <= w_next;
                            r_cnt      <= 4'd1;
                        end
                    end
                end
                ST_OPCODE: begin
                    if (out_ready) begin
                        r_state    <= ST_PAYLOAD;
                        r_out_data <= w_byte;
                        r_out_last <= w_last;
                        r_val      <= w_next;
                        r_cnt      <= w_cnt + 4'd1;
                    end
                end
                ST_PAYLOAD: begin
                    if (out_ready) begin
                        if (r_out_last) begin
                            r_state     <= ST_IDLE;
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                        end else begin
                            r_out_data <= w_byte;
                            r_out_last <= w_last;
                            r_val      <= w_next;
                            r_cnt      <= w_cnt + 4'd1;
                        end
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_out_valid <= 1'b0;
                    r_out_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wasm_const_encoder.sv
// -----------------------------------------------------------------------------
// tb_wasm_const_encoder
// Directed bench for wasm_const_encoder. Instance 0 emits opcodes, instance 1
// is built with EMIT_OPCODE=0. Expected byte streams are hand-encoded.
// -----------------------------------------------------------------------------
module tb_wasm_const_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [1:0]  in_type   [2];
    logic [63:0] in_value  [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic [7:0]  out_data  [2];
    logic        out_last  [2];

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_bytes [$];

    always #5 clk = ~clk;

    wasm_const_encoder #(.EMIT_OPCODE(1'b1)) u_dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_type(in_type[0]), .in_value(in_value[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_data(out_data[0]), .out_last(out_last[0])
    );

    wasm_const_encoder #(.EMIT_OPCODE(1'b0)) u_dut_noop (
        .clk(clk), .reset(reset),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_type(in_type[1]), .in_value(in_value[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_data(out_data[1]), .out_last(out_last[1])
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one request, wait (bounded) for acceptance, then scramble the
    // inputs to show they are ignored outside the accept cycle.
    task automatic send(input int sel, input string tag, input logic [1:0] t, input logic [63:0] v);
        for (int k = 0; k < 50 && !in_ready[sel]; k++) begin
            @(posedge clk); #1;
        end
        check({tag, " ready before accept"}, 64'(in_ready[sel]), 64'd1);
        in_valid[sel] = 1'b1;
        in_type[sel]  = t;
        in_value[sel] = v;
        @(posedge clk); #1;
        in_valid[sel] = 1'b0;
        in_type[sel]  = ~t;
        in_value[sel] = 64'ha5a5_5a5a_dead_beef;
        check({tag, " valid after accept"}, 64'(out_valid[sel]), 64'd1);
    endtask

    // Drain exp_bytes from one instance; optionally randomise out_ready and
    // verify that stalled bytes are held.
    task automatic recv(input int sel, input string tag, input bit rand_ready);
        int         idx = 0;
        int         cyc = 0;
        bit         stalled;
        logic [8:0] held;
        while (idx < exp_bytes.size() && cyc < 500) begin
            out_ready[sel] = rand_ready ? ($urandom_range(0, 1) != 0) : 1'b1;
            check($sformatf("%s valid/busy %0d", tag, idx),
                  64'({out_valid[sel], in_ready[sel]}), 64'b10);
            stalled = out_valid[sel] && !out_ready[sel];
            held    = {out_last[sel], out_data[sel]};
            if (out_valid[sel] && out_ready[sel]) begin
                check($sformatf("%s byte%0d", tag, idx),
                      64'({out_last[sel], out_data[sel]}),
                      64'({(idx == exp_bytes.size() - 1), exp_bytes[idx]}));
                idx++;
            end
            @(posedge clk); #1;
            cyc++;
            if (stalled)
                check($sformatf("%s held %0d", tag, idx),
                      64'({out_valid[sel], out_last[sel], out_data[sel]}),
                      64'({1'b1, held}));
        end
        check({tag, " byte count"}, 64'(idx), 64'(exp_bytes.size()));
        out_ready[sel] = 1'b1;
        check({tag, " back to idle"}, 64'({out_valid[sel], in_ready[sel]}), 64'b01);
    endtask

    initial begin
        reset = 1'b0;
        for (int s = 0; s < 2; s++) begin
            in_valid[s] = 1'b0; in_type[s] = 2'd0; in_value[s] = 64'd0; out_ready[s] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++)
            check($sformatf("reset state %0d", s),
                  64'({out_valid[s], out_data[s], out_last[s], in_ready[s]}), 64'd0);
        reset = 1'b1;
        #1;
        check("ready after release", 64'({in_ready[0], in_ready[1]}), 64'b11);

        exp_bytes = '{8'h43, 8'h00, 8'h00, 8'h00, 8'hc0};
        send(0, "f32 -2.0", 2'd2, 64'hffff_ffff_c000_0000);
        recv(0, "f32 -2.0", 1'b0);

        exp_bytes = '{8'h44, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hf0, 8'h3f};
        send(0, "f64 1.0", 2'd3, 64'h3ff0_0000_0000_0000);
        recv(0, "f64 1.0", 1'b0);

        exp_bytes = '{8'h41, 8'h7f};
        send(0, "i32 -1", 2'd0, 64'h0000_0000_ffff_ffff);
        recv(0, "i32 -1", 1'b0);

        exp_bytes = '{8'h41, 8'h3f};
        send(0, "i32 63", 2'd0, 64'd63);
        recv(0, "i32 63", 1'b0);

        exp_bytes = '{8'h41, 8'hc0, 8'h00};
        send(0, "i32 64", 2'd0, 64'd64);
        recv(0, "i32 64", 1'b0);

        exp_bytes = '{8'h41, 8'hff, 8'hff, 8'hff, 8'hff, 8'h07};
        send(0, "i32 max", 2'd0, 64'h0000_0000_7fff_ffff);
        recv(0, "i32 max", 1'b0);

        exp_bytes = '{8'h41, 8'h00};
        send(0, "i32 upper junk", 2'd0, 64'hdead_beef_0000_0000);
        recv(0, "i32 upper junk", 1'b0);

        exp_bytes = '{8'h42, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h7f};
        send(0, "i64 min", 2'd1, 64'h8000_0000_0000_0000);
        recv(0, "i64 min", 1'b0);

        exp_bytes = '{8'h44, 8'hef, 8'hcd, 8'hab, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
        send(0, "f64 stall", 2'd3, 64'h0123_4567_89ab_cdef);
        recv(0, "f64 stall", 1'b1);

        exp_bytes = '{8'h00, 8'h00, 8'h00, 8'hc0};
        send(1, "noop f32", 2'd2, 64'h0000_0000_c000_0000);
        recv(1, "noop f32", 1'b0);

        // Abandon an i64 after two handshakes.
        out_ready[0] = 1'b1;
        send(0, "abort i64", 2'd1, 64'h8000_0000_0000_0000);
        check("abort byte0", 64'(out_data[0]), 64'h42);
        @(posedge clk); #1;
        check("abort byte1", 64'(out_data[0]), 64'h80);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check("abort flushed", 64'({out_valid[0], out_last[0], in_ready[0]}), 64'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        exp_bytes = '{8'h41, 8'h05};
        send(0, "i32 5 after abort", 2'd0, 64'd5);
        recv(0, "i32 5 after abort", 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
